serial_cla_adder: RTL

//  Multi-cycle, digit-serial adder. Each cycle resolves one DIGIT-bit slice with a parallel

---
 rtl/serial_cla_adder.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/serial_cla_adder.sv
// ---------------------------------------------------------------------------
// serial_cla_adder
//   Digit-serial adder. Operands are captured on a valid/ready handshake and
//   summed one DIGIT-bit slice per cycle, LSB slice first. Inside a slice the
//   carries come from a parallel-prefix (group P/G) network, and the slice
//   carry-out is registered into the next slice. The result is held behind a
//   valid/ready handshake until the consumer takes it.
//
// Ports
//   clk_i        rising-edge clock
//   rst_ni       synchronous, active-low reset
//   in_valid_i   operand bundle valid
//   in_ready_o   operands accepted (high only in IDLE)
//   a_i, b_i     operands (WIDTH bits)
//   cin_i        carry into bit 0
//   out_valid_o  result valid (high only in DONE)
//   out_ready_i  consumer accepts the result
//   sum_o        low WIDTH bits of a+b+cin
//   cout_o       carry out of bit WIDTH-1
//   ovf_o        signed overflow (carry into MSB xor carry out)
//   grp_p_o      whole-word group propagate, AND of all a[i]^b[i]
// ---------------------------------------------------------------------------
module serial_cla_adder #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o,
  output logic             grp_p_o
);

  localparam int NUM_DIG = WIDTH / DIGIT;
  localparam int CNT_W   = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_DIG - 1);
  localparam logic [CNT_W-1:0] ZERO_CNT = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Kogge-Stone prefix over one slice. Returns the carry into every slice bit
  // (index 0 = incoming carry) plus the slice carry-out at index DIGIT.
  function automatic logic [DIGIT:0] prefix_carries(
    input logic [DIGIT-1:0] p,
    input logic [DIGIT-1:0] g,
    input logic             c0
  );
    logic [DIGIT-1:0] gg;
    logic [DIGIT-1:0] pp;
    logic [DIGIT-1:0] gn;
    logic [DIGIT-1:0] pn;
    logic [DIGIT:0]   c;
    gg = g;
    pp = p;
    for (int d = 1; d < DIGIT; d = d * 2) begin
      gn = gg;
      pn = pp;
      for (int i = 0; i < DIGIT; i++) begin
        if (i >= d) begin
          gn[i] = gg[i] | (pp[i] & gg[i-d]);
          pn[i] = pp[i] & pp[i-d];
        end else begin
          gn[i] = gg[i];
          pn[i] = pp[i];
        end
      end
      gg = gn;
      pp = pn;
    end
    // gg[i]/pp[i] now span bits [i:0] of the slice
    c[0] = c0;
    for (int i = 0; i < DIGIT; i++) begin
      c[i+1] = gg[i] | (pp[i] & c0);
    end
    return c;
  endfunction

  state_t             state_q,     state_d;
  logic [CNT_W-1:0]   cnt_q,       cnt_d;
  logic               carry_q,     carry_d;
  logic [WIDTH-1:0]   a_q,         a_d;
  logic [WIDTH-1:0]   b_q,         b_d;
  logic               grp_acc_q,   grp_acc_d;
  logic [WIDTH-1:0]   sum_q,       sum_d;
  logic               cout_q,      cout_d;
  logic               ovf_q,       ovf_d;
  logic               grp_p_q,     grp_p_d;
  logic               out_valid_q, out_valid_d;

  logic [DIGIT-1:0]   slice_a;
  logic [DIGIT-1:0]   slice_b;
  logic [DIGIT-1:0]   slice_p;
  logic [DIGIT-1:0]   slice_g;
  logic [DIGIT:0]     slice_c;
  logic [DIGIT-1:0]   slice_sum;

  // Current slice operands, bit propagate/generate and prefix carries
  always_comb begin
    slice_a   = a_q[cnt_q*DIGIT +: DIGIT];
    slice_b   = b_q[cnt_q*DIGIT +: DIGIT];
    slice_p   = slice_a ^ slice_b;
    slice_g   = slice_a & slice_b;
    slice_c   = prefix_carries(slice_p, slice_g, carry_q);
    slice_sum = slice_p ^ slice_c[DIGIT-1:0];
  end

  // Next-state and datapath update for the handshake FSM
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    a_d         = a_q;
    b_d         = b_q;
    grp_acc_d   = grp_acc_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    grp_p_d     = grp_p_q;
    out_valid_d = out_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid_i) begin
          a_d       = a_i;
          b_d       = b_i;
          carry_d   = cin_i;
          cnt_d     = ZERO_CNT;
          grp_acc_d = 1'b1;
          state_d   = ST_RUN;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_RUN: begin
        sum_d[cnt_q*DIGIT +: DIGIT] = slice_sum;
        carry_d   = slice_c[DIGIT];
        grp_acc_d = grp_acc_q & (&slice_p);
        if (cnt_q == LAST_CNT) begin
          // slice_c[DIGIT-1] is the carry into bit WIDTH-1
          cout_d      = slice_c[DIGIT];
          ovf_d       = slice_c[DIGIT-1] ^ slice_c[DIGIT];
          grp_p_d     = grp_acc_q & (&slice_p);
          out_valid_d = 1'b1;
          cnt_d       = ZERO_CNT;
          state_d     = ST_DONE;
        end else begin
          cnt_d       = cnt_q + ONE_CNT;
          state_d     = ST_RUN;
        end
      end
      ST_DONE: begin
        if (out_ready_i) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          state_d     = ST_DONE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        cnt_d       = ZERO_CNT;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      cnt_q       <= ZERO_CNT;
      carry_q     <= 1'b0;
      a_q         <= {WIDTH{1'b0}};
      b_q         <= {WIDTH{1'b0}};
      grp_acc_q   <= 1'b0;
      sum_q       <= {WIDTH{1'b0}};
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      grp_p_q     <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      a_q         <= a_d;
      b_q         <= b_d;
      grp_acc_q   <= grp_acc_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      grp_p_q     <= grp_p_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready_o  = (state_q == ST_IDLE);
  assign out_valid_o = out_valid_q;
  assign sum_o       = sum_q;
  assign cout_o      = cout_q;
  assign ovf_o       = ovf_q;
  assign grp_p_o     = grp_p_q;

endmodule
